// File: rtl/apb_gpio_irq.sv
// APB GPIO peripheral: push-pull/open-drain pads, atomic set/clear, byte strobes,
// and per-pin level/edge interrupts collected into a W1C status register.
module apb_gpio_irq #(
  parameter int unsigned PDATA_SIZE   = 32,
  parameter int unsigned PADDR_SIZE   = 4,
  parameter int unsigned INPUT_STAGES = 2
) (
  input  logic                    APB_CLK,
  input  logic                    APB_RESET_n,
  input  logic                    APB_PSEL,
  input  logic                    APB_PENABLE,
  input  logic [PADDR_SIZE-1:0]   APB_PADDR,
  input  logic                    APB_PWRITE,
  input  logic [PDATA_SIZE/8-1:0] APB_PSTRB,
  input  logic [PDATA_SIZE-1:0]   APB_PWDATA,
  output logic [PDATA_SIZE-1:0]   APB_PRDATA,
  output logic                    APB_PREADY,
  output logic                    APB_PSLVERR,
  input  logic [PDATA_SIZE-1:0]   GPIO_i,
  output logic [PDATA_SIZE-1:0]   GPIO_o,
  output logic [PDATA_SIZE-1:0]   GPIO_oe,
  output logic                    IRQ_o
);

  localparam int          NumBytes = PDATA_SIZE / 8;
  localparam int unsigned ArmW     = $clog2(INPUT_STAGES + 2);
  localparam logic [ArmW-1:0] ArmMax = ArmW'(INPUT_STAGES + 1);

  localparam logic [PADDR_SIZE-1:0] IdxMode    = PADDR_SIZE'(0);
  localparam logic [PADDR_SIZE-1:0] IdxDir     = PADDR_SIZE'(1);
  localparam logic [PADDR_SIZE-1:0] IdxOut     = PADDR_SIZE'(2);
  localparam logic [PADDR_SIZE-1:0] IdxIn      = PADDR_SIZE'(3);
  localparam logic [PADDR_SIZE-1:0] IdxIrqEn   = PADDR_SIZE'(4);
  localparam logic [PADDR_SIZE-1:0] IdxIrqType = PADDR_SIZE'(5);
  localparam logic [PADDR_SIZE-1:0] IdxIrqPol  = PADDR_SIZE'(6);
  localparam logic [PADDR_SIZE-1:0] IdxIrqStat = PADDR_SIZE'(7);
  localparam logic [PADDR_SIZE-1:0] IdxOutSet  = PADDR_SIZE'(8);
  localparam logic [PADDR_SIZE-1:0] IdxOutClr  = PADDR_SIZE'(9);

  function automatic logic [PDATA_SIZE-1:0] merge(input logic [PDATA_SIZE-1:0] old_v,
                                                  input logic [PDATA_SIZE-1:0] new_v,
                                                  input logic [PDATA_SIZE-1:0] m);
    return (old_v & ~m) | (new_v & m);
  endfunction

  logic                  access, err, wr_ok, rd_ok, armed;
  logic [PDATA_SIZE-1:0] strb_mask, wdata_m, w1c, hit, s;
  logic [PDATA_SIZE-1:0] mode_q, dir_q, out_q, en_q, type_q, pol_q, stat_q, prev_q;
  logic [PDATA_SIZE-1:0] mode_d, dir_d, out_d, en_d, type_d, pol_d, stat_d;
  logic [INPUT_STAGES-1:0][PDATA_SIZE-1:0] sync_q;
  logic [ArmW-1:0]       arm_q;

  assign access      = APB_PSEL & APB_PENABLE;
  assign err         = access & ((APB_PADDR > IdxOutClr) | (APB_PWRITE & (APB_PADDR == IdxIn)));
  assign wr_ok       = access & APB_PWRITE & ~err;
  assign rd_ok       = access & ~APB_PWRITE & ~err;
  assign APB_PREADY  = access;
  assign APB_PSLVERR = err;

  always_comb begin
    strb_mask = '0;
    for (int b = 0; b < NumBytes; b++) begin
      strb_mask[b*8 +: 8] = {8{APB_PSTRB[b]}};
    end
  end

  // Strobe-masked data doubles as the bit vector for set/clear style registers.
  assign wdata_m = APB_PWDATA & strb_mask;

  assign s     = sync_q[INPUT_STAGES-1];
  assign armed = (arm_q == ArmMax);
  assign hit   = (type_q & ((pol_q & s & ~prev_q) | (~pol_q & ~s & prev_q))) |
                 (~type_q & ~(s ^ pol_q));

  always_comb begin
    mode_d = mode_q;
    dir_d  = dir_q;
    out_d  = out_q;
    en_d   = en_q;
    type_d = type_q;
    pol_d  = pol_q;
    w1c    = '0;
    if (wr_ok) begin
      case (APB_PADDR)
        IdxMode:    mode_d = merge(mode_q, APB_PWDATA, strb_mask);
        IdxDir:     dir_d  = merge(dir_q, APB_PWDATA, strb_mask);
        IdxOut:     out_d  = merge(out_q, APB_PWDATA, strb_mask);
        IdxIrqEn:   en_d   = merge(en_q, APB_PWDATA, strb_mask);
        IdxIrqType: type_d = merge(type_q, APB_PWDATA, strb_mask);
        IdxIrqPol:  pol_d  = merge(pol_q, APB_PWDATA, strb_mask);
        IdxIrqStat: w1c    = wdata_m;
        IdxOutSet:  out_d  = out_q | wdata_m;
        IdxOutClr:  out_d  = out_q & ~wdata_m;
        default:    ;
      endcase
    end
    // New hits take priority over a same-cycle W1C.
    stat_d = (stat_q & ~w1c) | (en_q & hit & {PDATA_SIZE{armed}});
  end

  always_comb begin
    APB_PRDATA = '0;
    if (rd_ok) begin
      case (APB_PADDR)
        IdxMode:    APB_PRDATA = mode_q;
        IdxDir:     APB_PRDATA = dir_q;
        IdxOut:     APB_PRDATA = out_q;
        IdxIn:      APB_PRDATA = s;
        IdxIrqEn:   APB_PRDATA = en_q;
        IdxIrqType: APB_PRDATA = type_q;
        IdxIrqPol:  APB_PRDATA = pol_q;
        IdxIrqStat: APB_PRDATA = stat_q;
        default:    APB_PRDATA = '0;
      endcase
    end
  end

  always_ff @(posedge APB_CLK or negedge APB_RESET_n) begin
    if (!APB_RESET_n) begin
      mode_q  <= '0;
      dir_q   <= '0;
      out_q   <= '0;
      en_q    <= '0;
      type_q  <= '0;
      pol_q   <= '0;
      stat_q  <= '0;
      prev_q  <= '0;
      sync_q  <= '0;
      arm_q   <= '0;
      GPIO_o  <= '0;
      GPIO_oe <= '0;
      IRQ_o   <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      out_q   <= out_d;
      en_q    <= en_d;
      type_q  <= type_d;
      pol_q   <= pol_d;
      stat_q  <= stat_d;
      prev_q  <= s;
      sync_q[0] <= GPIO_i;
      for (int k = 1; k < INPUT_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      // Holds off detection until the synchroniser and edge history hold real data.
      if (!armed) arm_q <= arm_q + ArmW'(1);
      GPIO_o  <= out_q & ~mode_q;
      GPIO_oe <= dir_q & ~(mode_q & out_q);
      IRQ_o   <= |(stat_q & en_q);
    end
  end

endmodule

// File: tb/tb_apb_gpio_irq.sv
// Scoreboard bench for apb_gpio_irq: stimulus queues expected bus/pad responses,
// a negedge monitor pops and compares them.
module tb_apb_gpio_irq;
  localparam int unsigned W = 32;
  localparam int unsigned A = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [A-1:0] paddr = '0;
  logic [3:0]   pstrb = '0;
  logic [W-1:0] pwdata = '0, gpio_i = '0;
  logic [W-1:0] prdata, gpio_o, gpio_oe;
  logic         pready, pslverr, irq;
  logic         done = 1'b0;

  apb_gpio_irq #(.PDATA_SIZE(W), .PADDR_SIZE(A), .INPUT_STAGES(2)) dut (
    .APB_CLK     (clk),
    .APB_RESET_n (rst_n),
    .APB_PSEL    (psel),
    .APB_PENABLE (penable),
    .APB_PADDR   (paddr),
    .APB_PWRITE  (pwrite),
    .APB_PSTRB   (pstrb),
    .APB_PWDATA  (pwdata),
    .APB_PRDATA  (prdata),
    .APB_PREADY  (pready),
    .APB_PSLVERR (pslverr),
    .GPIO_i      (gpio_i),
    .GPIO_o      (gpio_o),
    .GPIO_oe     (gpio_oe),
    .IRQ_o       (irq)
  );

  always #5 clk = ~clk;

  typedef struct {logic [W-1:0] rdata; logic err; string name;} bus_exp_t;
  typedef struct {logic [W-1:0] o; logic [W-1:0] oe; logic irq; string name;} pin_exp_t;

  bus_exp_t bus_q[$];
  pin_exp_t pin_q[$];
  bus_exp_t be;
  pin_exp_t pe;
  int total = 0;
  int bad = 0;
  logic idle_ok;

  always @(negedge clk) begin
    if (psel && penable) begin
      total++;
      if (bus_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_access: got paddr=%0d, want no pending access", paddr);
      end else begin
        be = bus_q.pop_front();
        if (pready !== 1'b1 || pslverr !== be.err || prdata !== be.rdata) begin
          bad++;
          $display("FAIL %s: got pready=%b pslverr=%b prdata=%h, want pready=1 pslverr=%b prdata=%h",
                   be.name, pready, pslverr, prdata, be.err, be.rdata);
        end
      end
    end
    while (pin_q.size() > 0) begin
      pe = pin_q.pop_front();
      total++;
      idle_ok = (psel && penable) || (pready === 1'b0 && pslverr === 1'b0 && prdata === '0);
      if (gpio_o !== pe.o || gpio_oe !== pe.oe || irq !== pe.irq || !idle_ok) begin
        bad++;
        $display("FAIL %s: got o=%h oe=%h irq=%b idle_bus_ok=%b, want o=%h oe=%h irq=%b idle_bus_ok=1",
                 pe.name, gpio_o, gpio_oe, irq, idle_ok, pe.o, pe.oe, pe.irq);
      end
    end
    if (done) begin
      while (bus_q.size() > 0) begin
        be = bus_q.pop_front();
        total++;
        bad++;
        $display("FAIL %s: got no access, want pslverr=%b prdata=%h", be.name, be.err, be.rdata);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apb(input logic w, input logic [A-1:0] a, input logic [W-1:0] d,
                     input logic [3:0] s, input logic [W-1:0] exp_rd, input logic exp_err,
                     input string nm);
    @(posedge clk);
    #1;
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d; pstrb = s;
    bus_q.push_back('{exp_rd, exp_err, nm});
    @(posedge clk);
    #1;
    penable = 1'b1;
    @(posedge clk);
    #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wr(input logic [A-1:0] a, input logic [W-1:0] d, input logic [3:0] s,
                    input string nm);
    apb(1'b1, a, d, s, '0, 1'b0, nm);
  endtask

  task automatic rd(input logic [A-1:0] a, input logic [W-1:0] exp_v, input string nm);
    apb(1'b0, a, '0, 4'h0, exp_v, 1'b0, nm);
  endtask

  task automatic pins(input logic [W-1:0] o, input logic [W-1:0] oe, input logic i,
                      input string nm);
    pin_q.push_back('{o, oe, i, nm});
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    pins('0, '0, 1'b0, "reset_pads");
    rd(4'd0, '0, "reset_mode");
    rd(4'd2, '0, "reset_out");
    rd(4'd7, '0, "reset_stat");
    cyc(4);

    // Push-pull output with a single byte strobe.
    wr(4'd0, 32'h0, 4'hF, "t1_wr_mode");
    wr(4'd1, 32'hFF, 4'hF, "t1_wr_dir");
    wr(4'd2, 32'h1234_56A5, 4'b0001, "t1_wr_out");
    pins('0, 32'hFF, 1'b0, "t1_pads_lag");
    cyc(1);
    pins(32'hA5, 32'hFF, 1'b0, "t1_pads");
    rd(4'd2, 32'hA5, "t1_out");

    // Atomic set/clear.
    wr(4'd2, 32'hF0, 4'hF, "t2_wr_out");
    wr(4'd8, 32'h0F, 4'hF, "t2_set");
    rd(4'd2, 32'hFF, "t2_out_set");
    wr(4'd9, 32'h81, 4'hF, "t2_clr");
    rd(4'd2, 32'h7E, "t2_out_clr");
    wr(4'd8, 32'hFF, 4'h0, "t2_set_nostrb");
    rd(4'd2, 32'h7E, "t2_out_nostrb");
    rd(4'd8, '0, "t2_rd_set");

    // Open drain on bit 0.
    wr(4'd0, 32'h1, 4'hF, "t3_mode");
    wr(4'd1, 32'h1, 4'hF, "t3_dir");
    wr(4'd2, 32'h1, 4'hF, "t3_out1");
    cyc(1);
    pins('0, '0, 1'b0, "t3_od_high");
    wr(4'd2, 32'h0, 4'hF, "t3_out0");
    cyc(1);
    pins('0, 32'h1, 1'b0, "t3_od_low");
    wr(4'd0, 32'h0, 4'hF, "t3_mode0");
    wr(4'd1, 32'h0, 4'hF, "t3_dir0");

    // Rising edge on bit 2.
    wr(4'd5, 32'h4, 4'hF, "t4_type");
    wr(4'd6, 32'h4, 4'hF, "t4_pol");
    wr(4'd4, 32'h4, 4'hF, "t4_en");
    gpio_i[2] = 1'b1;
    cyc(3);
    pins('0, '0, 1'b0, "t4_irq_lag");
    cyc(1);
    pins('0, '0, 1'b1, "t4_irq_set");
    rd(4'd7, 32'h4, "t4_stat");
    wr(4'd7, 32'h4, 4'hF, "t4_w1c");
    pins('0, '0, 1'b1, "t4_w1c_lag");
    cyc(1);
    pins('0, '0, 1'b0, "t4_w1c_clr");
    cyc(3);
    rd(4'd7, '0, "t4_no_reset");
    gpio_i[2] = 1'b0;

    // Level-high on bit 5.
    wr(4'd4, 32'h0, 4'hF, "t5_en_off");
    wr(4'd5, 32'h0, 4'hF, "t5_type");
    wr(4'd6, 32'h20, 4'hF, "t5_pol");
    gpio_i[5] = 1'b1;
    cyc(3);
    wr(4'd4, 32'h20, 4'hF, "t5_en");
    cyc(2);
    pins('0, '0, 1'b1, "t5_irq");
    rd(4'd7, 32'h20, "t5_stat");
    wr(4'd7, 32'h20, 4'hF, "t5_w1c_held");
    pins('0, '0, 1'b1, "t5_irq_held");
    rd(4'd7, 32'h20, "t5_stat_held");
    wr(4'd4, 32'h0, 4'hF, "t5_en_off2");
    rd(4'd7, 32'h20, "t5_en_off_keeps");
    gpio_i[5] = 1'b0;
    cyc(3);
    wr(4'd7, 32'h20, 4'hF, "t5_w1c");
    cyc(1);
    pins('0, '0, 1'b0, "t5_clr");
    rd(4'd7, '0, "t5_stat_clr");

    // Error responses leave state untouched.
    gpio_i = 32'h3C00;
    wr(4'd2, 32'h3C, 4'hF, "t6_out");
    wr(4'd1, 32'hFF, 4'hF, "t6_dir");
    cyc(2);
    rd(4'd3, 32'h3C00, "t6_in");
    apb(1'b1, 4'd3, 32'hFFFF_FFFF, 4'hF, '0, 1'b1, "t6_wr_in");
    apb(1'b0, 4'd12, '0, 4'h0, '0, 1'b1, "t6_rd_12");
    apb(1'b1, 4'd15, 32'hFFFF_FFFF, 4'hF, '0, 1'b1, "t6_wr_15");
    rd(4'd2, 32'h3C, "t6_out_kept");
    rd(4'd1, 32'hFF, "t6_dir_kept");
    rd(4'd0, '0, "t6_mode_kept");
    pins(32'h3C, 32'hFF, 1'b0, "t6_pads");

    // Asynchronous reset during an access phase.
    @(posedge clk);
    #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'd2; pwdata = 32'hFF; pstrb = 4'hF;
    bus_q.push_back('{'0, 1'b0, "t7_rst_access"});
    @(posedge clk);
    #1;
    penable = 1'b1;
    #2;
    rst_n = 1'b0;
    pins('0, '0, 1'b0, "t7_rst_pads");
    @(posedge clk);
    #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    rd(4'd2, '0, "t7_out_rst");
    rd(4'd1, '0, "t7_dir_rst");
    cyc(1);
    done = 1'b1;
  end

endmodule
